// File: rtl/router_pkg.sv
// ============================================================================
// router_pkg: shared constants and types for the 1x3 router sync block.
// Revision: 1.0
// ============================================================================
`default_nettype none

package router_pkg;

  localparam int         NUM_PORTS       = 3;
  localparam logic [1:0] ADDR_INVALID    = 2'b11;
  localparam int         DEFAULT_TIMEOUT = 30;

  typedef logic [1:0] port_idx_t;

  // One-hot port select; the invalid address maps to no port at all.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_idx_t p);
    logic [NUM_PORTS-1:0] oh;
    oh = '0;
    if (p != ADDR_INVALID) oh[p] = 1'b1;
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/router_timeout_ctr.sv
// ============================================================================
// router_timeout_ctr: per-port idle timer, pulses soft_reset for one cycle
// after TIMEOUT consecutive valid-but-unread cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module router_timeout_ctr #(
  parameter int TIMEOUT = 30
) (
  input  logic clock,
  input  logic reset,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  localparam int               CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sr_q, sr_d;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = 1'b0;
    if (!vld || rd) begin
      cnt_d = '0;
    end else if (cnt_q == C_LAST) begin
      // Restart on the pulse edge so a still-full FIFO re-fires TIMEOUT later.
      cnt_d = '0;
      sr_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      sr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  assign soft_reset = sr_q;

endmodule

`default_nettype wire

// File: rtl/router_sync.sv
// ============================================================================
// router_sync: address latch, FIFO write steering, full-flag mux and per-port
// idle timers. Optional macro ROUTER_SYNC_DROP_CNT_EN adds drop_cnt output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module router_sync
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
`ifdef ROUTER_SYNC_DROP_CNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  port_idx_t            addr_q, addr_d;
  logic [NUM_PORTS-1:0] full_v, vld_v, rd_v, sr_v;

  assign full_v = {full_2, full_1, full_0};
  assign vld_v  = {~empty_2, ~empty_1, ~empty_0};
  assign rd_v   = {read_enb_2, read_enb_1, read_enb_0};

  assign addr_d = detect_add ? data_in : addr_q;

  always_ff @(posedge clock) begin
    if (reset) addr_q <= ADDR_INVALID;
    else       addr_q <= addr_d;
  end

  // Steering uses the registered address, so a header write goes to the old port.
  always_comb begin
    write_enb = write_enb_reg ? port_onehot(addr_q) : '0;
    fifo_full = 1'b0;
    if (addr_q != ADDR_INVALID) fifo_full = full_v[addr_q];
  end

  assign vld_out_0 = vld_v[0];
  assign vld_out_1 = vld_v[1];
  assign vld_out_2 = vld_v[2];

  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timer
      router_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clock      (clock),
        .reset      (reset),
        .vld        (vld_v[i]),
        .rd         (rd_v[i]),
        .soft_reset (sr_v[i])
      );
    end
  endgenerate

  assign soft_reset_0 = sr_v[0];
  assign soft_reset_1 = sr_v[1];
  assign soft_reset_2 = sr_v[2];

`ifdef ROUTER_SYNC_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;
  logic [8:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_q} + 9'(sr_v[0]) + 9'(sr_v[1]) + 9'(sr_v[2]);
    drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_router_sync.sv
// ============================================================================
// tb_router_sync: scoreboard bench for router_sync; expected output vectors
// are queued as each cycle is driven and compared at the following negedge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_router_sync;

  localparam int TIMEOUT = 30;

  logic       clock = 1'b0;
  logic       reset;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic [2:0] rd;
  logic [2:0] empty;
  logic [2:0] full;

  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
`ifdef ROUTER_SYNC_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  always #5 clock = ~clock;

  router_sync #(.TIMEOUT(TIMEOUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .read_enb_0    (rd[0]),
    .read_enb_1    (rd[1]),
    .read_enb_2    (rd[2]),
    .empty_0       (empty[0]),
    .empty_1       (empty[1]),
    .empty_2       (empty[2]),
    .full_0        (full[0]),
    .full_1        (full[1]),
    .full_2        (full[2]),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out_0     (vld_out_0),
    .vld_out_1     (vld_out_1),
    .vld_out_2     (vld_out_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2)
`ifdef ROUTER_SYNC_DROP_CNT_EN
    ,
    .drop_cnt      (drop_cnt)
`endif
  );

  typedef struct {
    string      tag;
    logic [9:0] outv;
    logic [7:0] drop;
  } exp_t;

  exp_t  sb_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "init";

  // Reference state: address, idle-run lengths, pulse flags, drop count.
  logic [1:0] m_addr;
  int         m_idle [3];
  logic [2:0] m_sr;
  int         m_drop;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] model_out();
    logic [2:0] we;
    logic       ff;
    we = 3'b000;
    ff = 1'b0;
    if (m_addr != 2'b11) begin
      if (write_enb_reg) we = 3'(1 << m_addr);
      ff = full[m_addr];
    end
    return {we, ff, ~empty, m_sr};
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_addr = 2'b11;
      m_sr   = 3'b000;
      m_drop = 0;
      for (int i = 0; i < 3; i++) m_idle[i] = 0;
    end else begin
      m_drop = m_drop + $countones(m_sr);
      if (m_drop > 255) m_drop = 255;
      if (detect_add) m_addr = data_in;
      for (int i = 0; i < 3; i++) begin
        if (!empty[i] && !rd[i]) begin
          m_idle[i]++;
          m_sr[i] = ((m_idle[i] % TIMEOUT) == 0);
        end else begin
          m_idle[i] = 0;
          m_sr[i]   = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle();
    exp_t e;
    e.tag  = phase;
    e.outv = model_out();
    e.drop = 8'(m_drop);
    sb_q.push_back(e);
    @(negedge clock);
    e = sb_q.pop_front();
    check_eq(e.tag,
             {6'b0, write_enb, fifo_full, vld_out_2, vld_out_1, vld_out_0,
              soft_reset_2, soft_reset_1, soft_reset_0},
             {6'b0, e.outv});
`ifdef ROUTER_SYNC_DROP_CNT_EN
    check_eq({e.tag, "_drop"}, {8'b0, drop_cnt}, {8'b0, e.drop});
`endif
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    reset = 1'b1; detect_add = 1'b0; data_in = 2'b00; write_enb_reg = 1'b0;
    rd = 3'b000; empty = 3'b111; full = 3'b010;
    @(posedge clock);
    model_edge();
    #1;

    phase = "reset";          run(3);
    reset = 1'b0;
    phase = "idle";           run(2);

    phase = "latch_addr1";    detect_add = 1'b1; data_in = 2'b01; run(1);
    detect_add = 1'b0; write_enb_reg = 1'b1;
    phase = "steer_p1_full1"; run(4);
    full = 3'b001;
    phase = "steer_p1_full0"; run(2);

    phase = "hdr_old_addr";   detect_add = 1'b1; data_in = 2'b10; run(1);
    detect_add = 1'b0;
    phase = "steer_p2";       full = 3'b100; run(2);

    phase = "latch_invalid";  detect_add = 1'b1; data_in = 2'b11; run(1);
    detect_add = 1'b0; full = 3'b111;
    phase = "steer_invalid";  run(3);
    write_enb_reg = 1'b0; full = 3'b000;

    phase = "timeout_p2";     empty = 3'b011; run(65);
    empty = 3'b111;           run(2);

    phase = "read_at_29";     empty = 3'b110; run(29);
    rd[0] = 1'b1;             run(1);
    rd[0] = 1'b0;
    phase = "restart_p0";     run(32);
    empty = 3'b111;           run(2);

    phase = "reset_at_20";    empty = 3'b110; run(20);
    reset = 1'b1;             run(1);
    reset = 1'b0;
    phase = "after_reset_p0"; run(31);
    empty = 3'b111;           run(2);

    phase = "multi_port";     empty = 3'b000; rd = 3'b100; run(31);
    rd = 3'b000; empty = 3'b111; run(2);

`ifdef ROUTER_SYNC_DROP_CNT_EN
    phase = "drop_double";    empty = 3'b100; run(32);
    phase = "drop_saturate";  run(130 * TIMEOUT);
    empty = 3'b111;           run(2);
    check_eq("drop_sat_final", {8'b0, drop_cnt}, 16'h00FF);
`endif

    if (sb_q.size() != 0) check_eq("sb_drain", 16'(sb_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/router_sync.md
Name: router_sync

Overview:
- Port-selection and flow-control controller between `router_fsm`, the input datapath and the three output FIFOs of the 1x3 router.
- Latches the destination address from the packet header and steers write enables to the selected FIFO.
- Muxes that FIFO's full flag back to the FSM as `fifo_full` and presents per-port valid outputs.
- Runs per-port idle timers; a port whose receiver does not read in time is soft-reset.

Parameters:
- TIMEOUT, 30: consecutive cycles with `vld_out_x`=1 and `read_enb_x`=0 before `soft_reset_x` fires; legal range 2..255.
- CNT_W, $clog2(TIMEOUT): timer counter width; derived, not overridden.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- detect_add  in  1  from `router_fsm`; header cycle, latch `data_in`.
- data_in  in  2  destination address (0,1,2 valid; 3 invalid).
- write_enb_reg  in  1  from `router_fsm`; write current byte to selected FIFO.
- read_enb_0/1/2  in  1 each  receiver read strobe per port.
- empty_0/1/2  in  1 each  FIFO empty flags.
- full_0/1/2  in  1 each  FIFO full flags.
- write_enb  out  3  one-hot FIFO write enables, bit i = port i.
- fifo_full  out  1  full flag of the selected FIFO.
- vld_out_0/1/2  out  1 each  data available at port.
- soft_reset_0/1/2  out  1 each  one-cycle FIFO flush pulse.

Behaviour:
- Reset (`reset`=1 at an edge; dominates all other inputs):
  - `addr_q` <= 2'b11.
  - All timer counters <= 0.
  - `soft_reset_0..2` <= 0.
  - Combinational outputs follow from this: `write_enb`=3'b000 and `fifo_full`=0; `vld_out` tracks `empty` even during reset.
- Address latch:
  - When `detect_add`=1, `addr_q` <= `data_in`; otherwise it holds.
  - The new address takes effect the cycle after `detect_add`.
  - If `detect_add` and `write_enb_reg` are both 1 in one cycle, the write uses the old `addr_q`.
- Write steering (combinational):
  - `write_enb` = `write_enb_reg` ? onehot(`addr_q`) : 0.
  - `addr_q`=3 gives `write_enb`=0; the write is dropped and no error is flagged.
- Full mux (combinational): `fifo_full` = `full_[addr_q]`; `addr_q`=3 gives 0.
- Valid outputs: `vld_out_x` = ~`empty_x`, combinational, zero latency.
- Per-port timer, evaluated at each edge:
  - If `vld_out_x`=0 or `read_enb_x`=1: `cnt` <= 0 and `soft_reset_x` <= 0.
  - Else if `cnt` == TIMEOUT-1: `cnt` <= 0 and `soft_reset_x` <= 1.
  - Else: `cnt` <= `cnt`+1 and `soft_reset_x` <= 0.
  - `soft_reset_x` therefore rises after exactly TIMEOUT consecutive sampled idle-valid edges and lasts exactly one cycle.
  - The counter restarts at 0 the same edge the pulse is set. If the FIFO stays non-empty (flush not yet seen), the next pulse follows TIMEOUT cycles later.
  - A read in the same cycle as `cnt`==TIMEOUT-1 wins: no pulse, counter cleared.
  - Ports are independent; simultaneous pulses on several ports are legal.
- Mid-operation reset: timers and address are cleared immediately, and a pending pulse is suppressed.
- No other state. No backpressure on the FSM beyond `fifo_full`.

Optional Feature:
- Macro ROUTER_SYNC_DROP_CNT_EN.
- Defined: adds output `drop_cnt` [7:0], an 8-bit saturating count of timeout events (soft-reset pulses) across all ports.
  - Increments by the number of `soft_reset_x` bits set in the cycle (0..3) and saturates at 255.
  - Cleared by `reset`.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package `router_pkg`:
  - NUM_PORTS=3.
  - ADDR_INVALID=2'b11.
  - DEFAULT_TIMEOUT=30.
  - Port-index type (2-bit).
- Sub-module `router_timeout_ctr`:
  - Inputs: `clock`, `reset`, `vld`, `rd`. Output: `soft_reset`. Parameter: TIMEOUT.
  - Instantiated three times.
- Top holds the address latch, steering and muxes.

Test Plan:
- Reset with `empty`=3'b111: `write_enb`=0, `fifo_full`=0, `vld_out`=0, all `soft_reset`=0; with `full_1`=1 and `addr_q`=3, `fifo_full` stays 0.
- `detect_add`=1 with `data_in`=2'b01, then `write_enb_reg`=1 for 4 cycles: `write_enb`=3'b010 each of those cycles. `full_1`=1 drives `fifo_full`=1; `full_0`=1 alone leaves `fifo_full`=0.
- `detect_add` with `data_in`=2'b11, then `write_enb_reg`=1: `write_enb`=3'b000 and `fifo_full`=0 regardless of `full_0..2`.
- `empty_2`=0 and `read_enb_2`=0 held: `soft_reset_2`=1 for exactly one cycle after 30 edges, 0 on all other cycles. With `empty_2` still 0, the second pulse follows 30 cycles later.
- `empty_0`=0, `read_enb_0` pulsed at idle cycle 29: no `soft_reset_0`, and the timer restarts (pulse 30 cycles after the read). Assert `reset` at idle cycle 20: no pulse, count restarts from 0.
- ROUTER_SYNC_DROP_CNT_EN: ports 0 and 1 time out in the same cycle → `drop_cnt` +2. Force 130 double timeouts → `drop_cnt` saturates at 255.
